// File: rtl/fifo_sample_writer_if.sv
// FIFO write-side bus between the sample writer (master) and synchronous_fifo (slave).
// Carries the write strobe/word and the FIFO occupancy/full status used for admission.
interface fifo_sample_writer_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] filter_fifo_data;
  logic [ADDR_WIDTH:0]   fifo_sample_num;
  logic                  full;

  modport master (
    output wr_en,
    output filter_fifo_data,
    input  fifo_sample_num,
    input  full
  );

  modport slave (
    input  wr_en,
    input  filter_fifo_data,
    output fifo_sample_num,
    output full
  );
endinterface

// File: rtl/fifo_sample_writer.sv
// Writes filtered X/Y/Z triples into the FIFO as atomic 3-word frames, with sticky overrun.
// Optional macro FIFO_WR_STANDBY_GATE_EN: STANDBY suppresses capture and clears queued frames.
module fifo_sample_writer #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned SAMPLE_WIDTH = 20
) (
  input  logic                    mems_clk,
  input  logic                    rst_n,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] xdata_in,
  input  logic [SAMPLE_WIDTH-1:0] ydata_in,
  input  logic [SAMPLE_WIDTH-1:0] zdata_in,
  input  logic                    STANDBY,
  input  logic                    ovr_clr,
  fifo_sample_writer_if.master    fifo,
  output logic                    FIFO_OVR,
  output logic                    busy
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH       = CNT_W'(1 << ADDR_WIDTH);
  localparam logic [CNT_W-1:0] FRAME_WORDS = CNT_W'(3);

  typedef enum logic [1:0] {IDLE, WR_X, WR_Y, WR_Z} state_t;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] x;
    logic [SAMPLE_WIDTH-1:0] y;
    logic [SAMPLE_WIDTH-1:0] z;
  } triple_t;

  state_t                state_q, state_d;
  triple_t               act_q, act_d, pend_q, pend_d, cand, new_frame;
  logic                  act_vld_q, act_vld_d, pend_vld_q, pend_vld_d;
  logic                  wr_en_d, ovr_d, busy_d, ovr_set, check, promote;
  logic                  stby, sv_eff, admit;
  logic [DATA_WIDTH-1:0] data_d;
  logic [CNT_W-1:0]      free_cnt;

`ifdef FIFO_WR_STANDBY_GATE_EN
  assign stby = STANDBY;
`else
  logic unused_standby;
  assign unused_standby = STANDBY;
  assign stby           = 1'b0;
`endif

  // FIFO word: sample, two reserved zeros, empty-read marker (0 on write), X marker
  function automatic logic [DATA_WIDTH-1:0] fmt_word(input logic [SAMPLE_WIDTH-1:0] s,
                                                     input logic xmark);
    return DATA_WIDTH'({s, 2'b00, 1'b0, xmark});
  endfunction

  assign sv_eff    = sample_valid & ~stby;
  assign new_frame = '{x: xdata_in, y: ydata_in, z: zdata_in};
  assign free_cnt  = DEPTH - fifo.fifo_sample_num;
  assign admit     = (free_cnt >= FRAME_WORDS) && !fifo.full;

  // State and output registers
  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q               <= IDLE;
      act_q                 <= '0;
      act_vld_q             <= 1'b0;
      pend_q                <= '0;
      pend_vld_q            <= 1'b0;
      fifo.wr_en            <= 1'b0;
      fifo.filter_fifo_data <= '0;
      FIFO_OVR              <= 1'b0;
      busy                  <= 1'b0;
    end else begin
      state_q               <= state_d;
      act_q                 <= act_d;
      act_vld_q             <= act_vld_d;
      pend_q                <= pend_d;
      pend_vld_q            <= pend_vld_d;
      fifo.wr_en            <= wr_en_d;
      fifo.filter_fifo_data <= data_d;
      FIFO_OVR              <= ovr_d;
      busy                  <= busy_d;
    end
  end

  // Next state; outputs are computed from the next state so they align with state_q
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    act_vld_d  = act_vld_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    wr_en_d    = 1'b0;
    data_d     = '0;
    ovr_set    = 1'b0;
    check      = 1'b0;
    promote    = 1'b0;
    cand       = act_q;

    case (state_q)
      IDLE: begin
        if (!stby && act_vld_q) begin
          check     = 1'b1;
          act_vld_d = 1'b0;
        end else if (!stby && pend_vld_q) begin
          check      = 1'b1;
          promote    = 1'b1;
          cand       = pend_q;
          act_d      = pend_q;
          pend_vld_d = 1'b0;
        end
        if (check) begin
          if (admit) begin
            state_d = WR_X;
            wr_en_d = 1'b1;
            data_d  = fmt_word(cand.x, 1'b1);
          end else begin
            ovr_set = 1'b1;
          end
        end
      end
      WR_X: begin
        state_d = WR_Y;
        wr_en_d = 1'b1;
        data_d  = fmt_word(act_q.y, 1'b0);
      end
      WR_Y: begin
        state_d = WR_Z;
        wr_en_d = 1'b1;
        data_d  = fmt_word(act_q.z, 1'b0);
      end
      default: state_d = IDLE;
    endcase

    // Capture: straight to active only when nothing else is queued, else one-deep pending
    if (sv_eff) begin
      if (state_q == IDLE && !act_vld_q && !pend_vld_q) begin
        act_d     = new_frame;
        act_vld_d = 1'b1;
      end else if (!pend_vld_q || promote) begin
        pend_d     = new_frame;
        pend_vld_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    if (stby) begin
      pend_vld_d = 1'b0;
      if (state_q == IDLE) act_vld_d = 1'b0;
    end

    ovr_d  = ovr_set | (FIFO_OVR & ~ovr_clr);
    busy_d = (state_d != IDLE) | act_vld_d | pend_vld_d;
  end

endmodule

// File: tb/tb_fifo_sample_writer.sv
// Directed self-checking bench for fifo_sample_writer with a behavioural FIFO occupancy model.
module tb_fifo_sample_writer;

  logic        mems_clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [19:0] xdata_in, ydata_in, zdata_in;
  logic        STANDBY;
  logic        ovr_clr;
  logic        FIFO_OVR;
  logic        busy;

  logic [4:0]  occ = 5'd0;
  logic [4:0]  occ_val;
  logic        occ_ld;
  logic        full_force;
  logic [23:0] log_q[$];

  int checks = 0;
  int errors = 0;

  always #5 mems_clk = ~mems_clk;

  fifo_sample_writer_if #(.DATA_WIDTH(24), .ADDR_WIDTH(4)) fifo_bus ();

  assign fifo_bus.fifo_sample_num = occ;
  assign fifo_bus.full            = (occ == 5'd16) | full_force;

  fifo_sample_writer #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .SAMPLE_WIDTH(20)) dut (
    .mems_clk     (mems_clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .xdata_in     (xdata_in),
    .ydata_in     (ydata_in),
    .zdata_in     (zdata_in),
    .STANDBY      (STANDBY),
    .ovr_clr      (ovr_clr),
    .fifo         (fifo_bus.master),
    .FIFO_OVR     (FIFO_OVR),
    .busy         (busy)
  );

  // FIFO model: no reads, occupancy counts writes; log records every written word
  always @(posedge mems_clk) begin
    if (occ_ld) occ <= occ_val;
    else if (fifo_bus.wr_en) occ <= occ + 5'd1;
    if (fifo_bus.wr_en) log_q.push_back(fifo_bus.filter_fifo_data);
  end

  function automatic logic [23:0] w(input logic [19:0] s, input logic xm);
    return {s, 3'b000, xm};
  endfunction

  task automatic step();
    @(posedge mems_clk);
    #1;
  endtask

  task automatic set_occ(input logic [4:0] v);
    occ_val = v;
    occ_ld  = 1'b1;
    step();
    occ_ld  = 1'b0;
    log_q.delete();
  endtask

  // Drive a one-cycle strobe in the current cycle; returns in the admission cycle
  task automatic strobe(input logic [19:0] x, input logic [19:0] y, input logic [19:0] z);
    sample_valid = 1'b1;
    xdata_in = x; ydata_in = y; zdata_in = z;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic clear_ovr();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_valid = 1'b0; STANDBY = 1'b0; ovr_clr = 1'b0;
    xdata_in = '0; ydata_in = '0; zdata_in = '0;
    occ_ld = 1'b0; occ_val = '0; full_force = 1'b0;
    step(); step();
    checks++;
    if ({fifo_bus.wr_en, FIFO_OVR, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: wr_en/ovr/busy=%b expected 000", {fifo_bus.wr_en, FIFO_OVR, busy});
    end
    checks++;
    if (fifo_bus.filter_fifo_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 000000", fifo_bus.filter_fifo_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    logic [23:0] exp_w[3];
    exp_w[0] = 24'h123451; exp_w[1] = 24'hABCDE0; exp_w[2] = 24'h000010;
    set_occ(5'd0);
    strobe(20'h12345, 20'hABCDE, 20'h00001);
    checks++;
    if (fifo_bus.wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_admit_cycle: wr_en=%b busy=%b expected wr_en=0 busy=1", fifo_bus.wr_en, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fifo_bus.wr_en !== 1'b1 || fifo_bus.filter_fifo_data !== exp_w[i]) begin
        errors++;
        $display("FAIL single_word%0d: wr_en=%b data=%h expected 1 %h", i, fifo_bus.wr_en,
                 fifo_bus.filter_fifo_data, exp_w[i]);
      end
    end
    step();
    checks++;
    if ({fifo_bus.wr_en, busy, FIFO_OVR} !== 3'b000 || log_q.size() != 3) begin
      errors++;
      $display("FAIL single_done: wr_en/busy/ovr=%b writes=%0d expected 000 3",
               {fifo_bus.wr_en, busy, FIFO_OVR}, log_q.size());
    end
  endtask

  task automatic test_fill_drop();
    set_occ(5'd0);
    for (int f = 0; f < 5; f++) begin
      strobe(20'(f + 1), 20'(f + 16), 20'(f + 32));
      repeat (4) step();
    end
    checks++;
    if (occ !== 5'd15 || log_q.size() != 15 || FIFO_OVR !== 1'b0) begin
      errors++;
      $display("FAIL fill_five: occ=%0d writes=%0d ovr=%b expected 15 15 0", occ, log_q.size(), FIFO_OVR);
    end
    checks++;
    if (log_q[12] !== w(20'h5, 1'b1) || log_q[14] !== w(20'h24, 1'b0)) begin
      errors++;
      $display("FAIL fill_frame5_words: x=%h z=%h expected %h %h", log_q[12], log_q[14],
               w(20'h5, 1'b1), w(20'h24, 1'b0));
    end
    // Sixth frame fails admission in the same cycle ovr_clr is pulsed
    strobe(20'hFFFFF, 20'hEEEEE, 20'hDDDDD);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    checks++;
    if (FIFO_OVR !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_clr_collision: ovr=%b expected 1", FIFO_OVR);
    end
    repeat (4) step();
    checks++;
    if (log_q.size() != 15 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_writes: writes=%0d busy=%b expected 15 0", log_q.size(), busy);
    end
    clear_ovr();
    checks++;
    if (FIFO_OVR !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: ovr=%b expected 0", FIFO_OVR);
    end
  endtask

  task automatic test_boundary();
    set_occ(5'd13);
    strobe(20'h11111, 20'h22222, 20'h33333);
    repeat (4) step();
    checks++;
    if (log_q.size() != 3 || occ !== 5'd16 || FIFO_OVR !== 1'b0) begin
      errors++;
      $display("FAIL bound_three_free: writes=%0d occ=%0d ovr=%b expected 3 16 0", log_q.size(), occ, FIFO_OVR);
    end
    strobe(20'h44444, 20'h55555, 20'h66666);
    repeat (4) step();
    checks++;
    if (log_q.size() != 3 || FIFO_OVR !== 1'b1) begin
      errors++;
      $display("FAIL bound_zero_free: writes=%0d ovr=%b expected 3 1", log_q.size(), FIFO_OVR);
    end
    clear_ovr();
    set_occ(5'd0);
    full_force = 1'b1;
    strobe(20'h77777, 20'h88888, 20'h99999);
    repeat (4) step();
    full_force = 1'b0;
    checks++;
    if (log_q.size() != 0 || FIFO_OVR !== 1'b1) begin
      errors++;
      $display("FAIL bound_full_flag: writes=%0d ovr=%b expected 0 1", log_q.size(), FIFO_OVR);
    end
    clear_ovr();
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_w[6];
    exp_w[0] = 24'hA00011; exp_w[1] = 24'hA00020; exp_w[2] = 24'hA00030;
    exp_w[3] = 24'hB00011; exp_w[4] = 24'hB00020; exp_w[5] = 24'hB00030;
    set_occ(5'd0);
    sample_valid = 1'b1;
    xdata_in = 20'hA0001; ydata_in = 20'hA0002; zdata_in = 20'hA0003;
    step();
    xdata_in = 20'hB0001; ydata_in = 20'hB0002; zdata_in = 20'hB0003;
    step();
    xdata_in = 20'hC0001; ydata_in = 20'hC0002; zdata_in = 20'hC0003;
    checks++;
    if (fifo_bus.wr_en !== 1'b1 || fifo_bus.filter_fifo_data !== 24'hA00011) begin
      errors++;
      $display("FAIL b2b_latency: wr_en=%b data=%h expected 1 a00011", fifo_bus.wr_en, fifo_bus.filter_fifo_data);
    end
    step();
    sample_valid = 1'b0;
    checks++;
    if (FIFO_OVR !== 1'b1) begin
      errors++;
      $display("FAIL b2b_third_dropped: ovr=%b expected 1", FIFO_OVR);
    end
    step(); step();
    checks++;
    if (fifo_bus.wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap_cycle: wr_en=%b busy=%b expected 0 1", fifo_bus.wr_en, busy);
    end
    step();
    checks++;
    if (fifo_bus.wr_en !== 1'b1 || fifo_bus.filter_fifo_data !== 24'hB00011) begin
      errors++;
      $display("FAIL b2b_pending_start: wr_en=%b data=%h expected 1 b00011", fifo_bus.wr_en, fifo_bus.filter_fifo_data);
    end
    repeat (3) step();
    checks++;
    if (log_q.size() != 6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: writes=%0d busy=%b expected 6 0", log_q.size(), busy);
    end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h expected %h", i, log_q[i], exp_w[i]);
      end
    end
    clear_ovr();
  endtask

  task automatic test_reset_mid_frame();
    set_occ(5'd0);
    strobe(20'h0F0F0, 20'h1E1E1, 20'h2D2D2);
    step(); step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_bus.wr_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_async: wr_en/busy=%b expected 00", {fifo_bus.wr_en, busy});
    end
    #2;
    rst_n = 1'b1;
    set_occ(5'd0);
    strobe(20'h3C3C3, 20'h4B4B4, 20'h5A5A5);
    repeat (4) step();
    checks++;
    if (log_q.size() != 3 || log_q[0] !== 24'h3C3C31 || log_q[1] !== 24'h4B4B40 || log_q[2] !== 24'h5A5A50) begin
      errors++;
      $display("FAIL rst_mid_next_frame: writes=%0d first=%h expected 3 3c3c31/4b4b40/5a5a50",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : 24'h0);
    end
  endtask

  task automatic test_standby();
    int exp_writes;
`ifdef FIFO_WR_STANDBY_GATE_EN
    exp_writes = 0;
`else
    exp_writes = 9;
`endif
    set_occ(5'd0);
    STANDBY = 1'b1;
    for (int f = 0; f < 3; f++) begin
      strobe(20'(f + 100), 20'(f + 200), 20'(f + 300));
      repeat (3) step();
    end
    repeat (4) step();
    STANDBY = 1'b0;
    checks++;
    if (log_q.size() != exp_writes || FIFO_OVR !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL standby_writes: writes=%0d ovr=%b busy=%b expected %0d 0 0",
               log_q.size(), FIFO_OVR, busy, exp_writes);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_drop();
    test_boundary();
    test_back_to_back();
    test_reset_mid_frame();
    test_standby();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
